// File: rtl/timer_ctrl_master_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_master_if
// Description : Avalon-MM bus bundle between timer_ctrl_master (initiator)
//               and the interval-timer slave, plus the timer's level IRQ.
//   av_address     [2:0]  timer word address          (master -> slave)
//   av_chipselect         bus select                  (master -> slave)
//   av_write_n            active-low write            (master -> slave)
//   av_writedata   [15:0] write data                  (master -> slave)
//   av_readdata    [15:0] read data                   (slave  -> master)
//   av_waitrequest        stall                       (slave  -> master)
//   irq                   timer interrupt, level high (slave  -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface timer_ctrl_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;
  logic        irq;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata,
    input  av_readdata,
    input  av_waitrequest,
    input  irq
  );

  modport slave (
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata,
    output av_readdata,
    output av_waitrequest,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/timer_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_master
// Description : Avalon-MM initiator that programs and services the interval
//               timer. Turns local start/stop/snapshot commands into timer
//               register accesses and acknowledges timer IRQs by clearing the
//               status register, counting each serviced timeout.
// Ports       :
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_start/stop/snap   command pulses, sampled only while cmd_ready=1
//   cmd_period [31:0]     period for cmd_start ({period_h, period_l})
//   cmd_continuous        CONT bit for cmd_start
//   cmd_ready             IDLE, irq low, commands accepted this cycle
//   snap_value [31:0]     last snapshot {snap_h, snap_l}; snap_valid pulses
//   timeout_pulse         one pulse per serviced timeout
//   timeout_count         serviced timeouts, wraps modulo 2^CNT_W
//   bus                   Avalon-MM master modport + timer irq
// Parameters  : READ_LATENCY (>= 1) cycles from read command to readdata,
//               CNT_W width of timeout_count
// Revision    : 1.0  initial release
// ============================================================================
module timer_ctrl_master #(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_stop,
  input  logic                  cmd_snap,
  output logic                  cmd_ready,
  output logic [31:0]           snap_value,
  output logic                  snap_valid,
  output logic                  timeout_pulse,
  output logic [CNT_W-1:0]      timeout_count,
  timer_ctrl_master_if.master   bus
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  // Timer register word addresses
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PL     = 3'd2;
  localparam logic [2:0] ADDR_PH     = 3'd3;
  localparam logic [2:0] ADDR_SNAPL  = 3'd4;
  localparam logic [2:0] ADDR_SNAPH  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLR_ST  = 4'd1,
    S_SETTLE  = 4'd2,
    S_STOP    = 4'd3,
    S_WR_PL   = 4'd4,
    S_WR_PH   = 4'd5,
    S_WR_CTRL = 4'd6,
    S_WR_SNAP = 4'd7,
    S_RD_SL   = 4'd8,
    S_WAIT_SL = 4'd9,
    S_RD_SH   = 4'd10,
    S_WAIT_SH = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [31:0]        period_q, period_d;
  logic               cont_q, cont_d;
  logic [15:0]        snap_l_q, snap_l_d;
  logic [31:0]        snap_value_q, snap_value_d;
  logic               snap_valid_q, snap_valid_d;
  logic               timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0]   timeout_count_q, timeout_count_d;
  // Set for the single IDLE cycle that follows any sequence; nothing is
  // accepted or serviced in that cycle.
  logic               ret_q, ret_d;

  logic               cs;
  logic               wr_n;
  logic [2:0]         addr;
  logic [15:0]        wdata;
  logic               done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      lat_q           <= '0;
      period_q        <= '0;
      cont_q          <= 1'b0;
      snap_l_q        <= '0;
      snap_value_q    <= '0;
      snap_valid_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_count_q <= '0;
      ret_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      lat_q           <= lat_d;
      period_q        <= period_d;
      cont_q          <= cont_d;
      snap_l_q        <= snap_l_d;
      snap_value_q    <= snap_value_d;
      snap_valid_q    <= snap_valid_d;
      timeout_pulse_q <= timeout_pulse_d;
      timeout_count_q <= timeout_count_d;
      ret_q           <= ret_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lat_d           = lat_q;
    period_d        = period_q;
    cont_d          = cont_q;
    snap_l_d        = snap_l_q;
    snap_value_d    = snap_value_q;
    snap_valid_d    = 1'b0;
    timeout_pulse_d = 1'b0;
    timeout_count_d = timeout_count_q;
    ret_d           = 1'b0;
    cs              = 1'b0;
    wr_n            = 1'b1;
    addr            = ADDR_STATUS;
    wdata           = 16'h0000;
    // An access completes on the first edge where the slave is not stalling.
    done            = !bus.av_waitrequest;

    case (state_q)
      S_IDLE: begin
        if (!ret_q) begin
          // irq outranks every command; losers of the same cycle are dropped.
          if (bus.irq) begin
            state_d = S_CLR_ST;
          end else if (cmd_stop) begin
            state_d = S_STOP;
          end else if (cmd_start) begin
            state_d  = S_WR_PL;
            period_d = cmd_period;
            cont_d   = cmd_continuous;
          end else if (cmd_snap) begin
            state_d = S_WR_SNAP;
          end
        end
      end
      S_CLR_ST: begin
        cs   = 1'b1;
        wr_n = 1'b0;
        addr = ADDR_STATUS;
        if (done) begin
          timeout_count_d = timeout_count_q + CNT_W'(1);
          timeout_pulse_d = 1'b1;
          state_d         = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // irq drops one cycle after the clear; idle here so it is not recounted.
        state_d = S_IDLE;
        ret_d   = 1'b1;
      end
      S_STOP: begin
        cs    = 1'b1;
        wr_n  = 1'b0;
        addr  = ADDR_CTRL;
        wdata = 16'h0008;
        if (done) begin
          state_d = S_IDLE;
          ret_d   = 1'b1;
        end
      end
      S_WR_PL: begin
        cs    = 1'b1;
        wr_n  = 1'b0;
        addr  = ADDR_PL;
        wdata = period_q[15:0];
        if (done) state_d = S_WR_PH;
      end
      S_WR_PH: begin
        cs    = 1'b1;
        wr_n  = 1'b0;
        addr  = ADDR_PH;
        wdata = period_q[31:16];
        if (done) state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        cs    = 1'b1;
        wr_n  = 1'b0;
        addr  = ADDR_CTRL;
        // {STOP=0, START=1, CONT, ITO=1}
        wdata = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
        if (done) begin
          state_d = S_IDLE;
          ret_d   = 1'b1;
        end
      end
      S_WR_SNAP: begin
        cs   = 1'b1;
        wr_n = 1'b0;
        addr = ADDR_SNAPL;
        if (done) state_d = S_RD_SL;
      end
      S_RD_SL: begin
        cs   = 1'b1;
        addr = ADDR_SNAPL;
        if (done) begin
          state_d = S_WAIT_SL;
          lat_d   = '0;
        end
      end
      S_WAIT_SL: begin
        if (lat_q == LAT_LAST) begin
          snap_l_d = bus.av_readdata;
          state_d  = S_RD_SH;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_RD_SH: begin
        cs   = 1'b1;
        addr = ADDR_SNAPH;
        if (done) begin
          state_d = S_WAIT_SH;
          lat_d   = '0;
        end
      end
      S_WAIT_SH: begin
        if (lat_q == LAT_LAST) begin
          snap_value_d = {bus.av_readdata, snap_l_q};
          snap_valid_d = 1'b1;
          state_d      = S_IDLE;
          ret_d        = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.av_chipselect = cs;
  assign bus.av_write_n    = wr_n;
  assign bus.av_address    = addr;
  assign bus.av_writedata  = wdata;

  // Held low while reset is asserted even though the state is already IDLE.
  assign cmd_ready     = reset_n && (state_q == S_IDLE) && !ret_q && !bus.irq;
  assign snap_value    = snap_value_q;
  assign snap_valid    = snap_valid_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_count = timeout_count_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_ctrl_master
// Description : Self-checking bench for timer_ctrl_master. Stimulus pushes the
//               expected bus accesses, snapshots and timeout counts into
//               queues; an independent monitor pops and compares them when
//               the DUT presents them. A small timer-slave model supplies
//               readdata, waitrequest and the irq level.
// Revision    : 1.0  initial release
// ============================================================================
module tb_timer_ctrl_master;
  localparam int CNT_W = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic [31:0]       cmd_period = '0;
  logic              cmd_continuous = 1'b0;
  logic              cmd_stop = 1'b0;
  logic              cmd_snap = 1'b0;
  logic              cmd_ready;
  logic [31:0]       snap_value;
  logic              snap_valid;
  logic              timeout_pulse;
  logic [CNT_W-1:0]  timeout_count;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.READ_LATENCY(1), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_start      (cmd_start),
    .cmd_period     (cmd_period),
    .cmd_continuous (cmd_continuous),
    .cmd_stop       (cmd_stop),
    .cmd_snap       (cmd_snap),
    .cmd_ready      (cmd_ready),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid),
    .timeout_pulse  (timeout_pulse),
    .timeout_count  (timeout_count),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [2:0]  a;
    logic [15:0] d;
  } xact_t;

  xact_t            exp_bus[$];
  logic [31:0]      exp_snap[$];
  int               exp_cnt[$];

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               irq_req = 0;   // written by stimulus only
  int               irq_ack = 0;   // written by slave model only
  int               model_count = 0;
  int               ph_stall_n = 0;
  logic             stall_en = 1'b0;
  logic [15:0]      slave_sl = '0;
  logic [15:0]      slave_sh = '0;

  assign bus.irq = (irq_req != irq_ack);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected transactions ----------------
  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    exp_bus.push_back({1'b1, a, d});
  endtask

  task automatic push_r(input logic [2:0] a);
    exp_bus.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic exp_start(input logic [31:0] p, input logic c);
    push_w(3'd2, p[15:0]);
    push_w(3'd3, p[31:16]);
    // control word: START (bit2) | CONT (bit1) | ITO (bit0)
    push_w(3'd1, 16'(4 + (c ? 2 : 0) + 1));
  endtask

  task automatic exp_irq();
    push_w(3'd0, 16'h0000);
    model_count = (model_count + 1) % (1 << CNT_W);
    exp_cnt.push_back(model_count);
  endtask

  task automatic exp_snapshot();
    push_w(3'd4, 16'h0000);
    push_r(3'd4);
    push_r(3'd5);
    exp_snap.push_back({slave_sh, slave_sl});
  endtask

  // Called on a negedge where cmd_ready=1; returns two negedges later.
  task automatic issue(input logic st, input logic sp, input logic sn,
                       input logic [31:0] p, input logic c,
                       input logic mid_irq, input logic stray);
    cmd_start = st; cmd_stop = sp; cmd_snap = sn;
    cmd_period = p; cmd_continuous = c;
    if (sp)      push_w(3'd1, 16'h0008);
    else if (st) exp_start(p, c);
    else if (sn) exp_snapshot();
    @(negedge clk);
    cmd_start = 1'b0; cmd_snap = 1'b0; cmd_stop = stray;
    cmd_period = $urandom; cmd_continuous = ~c;
    if (mid_irq) begin
      irq_req++;
      exp_irq();
    end
    @(negedge clk);
    cmd_stop = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready still %0b after %0d cycles, need 1", cmd_ready, n);
    end
  endtask

  task automatic raise_irq();
    irq_req++;
    exp_irq();
    @(negedge clk);
  endtask

  // ---------------- slave model ----------------
  initial begin
    int          drop_cnt = 0;
    int          ph_used = 0;
    logic        rd_pend = 1'b0;
    logic [2:0]  rd_addr = '0;
    bus.av_waitrequest = 1'b0;
    bus.av_readdata    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.av_chipselect && !bus.av_waitrequest) begin
        if (bus.av_write_n) begin
          rd_pend = 1'b1;
          rd_addr = bus.av_address;
        end else if (bus.av_address == 3'd0) begin
          drop_cnt = 2;
        end
      end
      @(posedge clk);
      #1;
      if (rd_pend && rd_addr == 3'd4)      bus.av_readdata = slave_sl;
      else if (rd_pend && rd_addr == 3'd5) bus.av_readdata = slave_sh;
      else                                 bus.av_readdata = 16'($urandom);
      rd_pend = 1'b0;
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) irq_ack++;
      end
      if (bus.av_chipselect && bus.av_address == 3'd3 && !bus.av_write_n && ph_used < ph_stall_n) begin
        bus.av_waitrequest = 1'b1;
        ph_used++;
      end else begin
        if (!(bus.av_chipselect && bus.av_address == 3'd3)) ph_used = 0;
        bus.av_waitrequest = stall_en && bus.av_chipselect && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    xact_t        e;
    logic         stalled = 1'b0;
    logic [20:0]  held = '0;
    logic [31:0]  es;
    int           ec;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("stall_hold", {bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata}, held);
        stalled = 1'b0;
        if (bus.av_chipselect) begin
          if (bus.av_waitrequest) begin
            stalled = 1'b1;
            held = {1'b1, bus.av_write_n, bus.av_address, bus.av_writedata};
          end else if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%0h, none expected",
                     !bus.av_write_n, bus.av_address, bus.av_writedata);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_dir", !bus.av_write_n, e.wr);
            chk("bus_addr", bus.av_address, e.a);
            if (e.wr) chk("bus_wdata", bus.av_writedata, e.d);
          end
        end
        if (snap_valid) begin
          if (exp_snap.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL snap_unexpected: got snap_valid with %0h, none expected", snap_value);
          end else begin
            es = exp_snap.pop_front();
            chk("snap_value", snap_value, es);
          end
        end
        if (timeout_pulse) begin
          if (exp_cnt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_unexpected: got pulse with count %0d, none expected", timeout_count);
          end else begin
            ec = exp_cnt.pop_front();
            chk("timeout_count", timeout_count, ec);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          c0;
    int          op;
    logic [31:0] per;
    logic        cont;
    logic        mid;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", bus.av_chipselect, 1'b0);
    chk("rst_write_n", bus.av_write_n, 1'b1);
    chk("rst_addr", bus.av_address, 3'd0);
    chk("rst_wdata", bus.av_writedata, 16'h0);
    chk("rst_snap_value", snap_value, 32'h0);
    chk("rst_snap_valid", snap_valid, 1'b0);
    chk("rst_timeout_pulse", timeout_pulse, 1'b0);
    chk("rst_timeout_count", timeout_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Start: three writes, one return cycle, then ready
    c0 = cyc;
    issue(1'b1, 1'b0, 1'b0, 32'h0007A11F, 1'b1, 1'b0, 1'b0);
    wait_ready();
    chk("start_latency", cyc - c0, 5);

    // IRQ service: one clear, one pulse, count 0 -> 1
    raise_irq();
    wait_ready();
    repeat (4) @(negedge clk);
    chk("count_after_irq", timeout_count, 1);

    // Snapshot
    slave_sl = 16'h1234;
    slave_sh = 16'h0003;
    issue(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_ready();
    chk("snap_hold", snap_value, 32'h00031234);

    // Same-cycle stop/start/snap: only the stop write happens
    issue(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    wait_ready();

    // Three stalled cycles on WR_PH
    ph_stall_n = 3;
    c0 = cyc;
    issue(1'b1, 1'b0, 1'b0, 32'hBEEF0000, 1'b0, 1'b0, 1'b0);
    wait_ready();
    chk("stalled_start_latency", cyc - c0, 8);
    ph_stall_n = 0;

    // Randomised mix with random stalls
    stall_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      wait_ready();
      op   = $urandom_range(0, 6);
      per  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      cont = 1'($urandom_range(0, 1));
      mid  = ($urandom_range(0, 3) == 0);
      slave_sl = 16'($urandom);
      slave_sh = 16'($urandom);
      case (op)
        0: issue(1'b1, 1'b0, 1'b0, per, cont, mid, 1'($urandom_range(0, 1)));
        1: issue(1'b0, 1'b1, 1'b0, per, cont, mid, 1'b0);
        2: issue(1'b0, 1'b0, 1'b1, per, cont, mid, 1'b0);
        3: issue(1'b1, 1'b1, 1'b1, per, cont, mid, 1'b0);
        4: issue(1'b1, 1'b0, 1'b1, per, cont, mid, 1'b0);
        5: raise_irq();
        default: issue(1'b0, 1'b0, 1'b1, per, cont, 1'b1, 1'b0);
      endcase
    end
    wait_ready();
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of WR_PH
    issue(1'b1, 1'b0, 1'b0, 32'hCAFE0001, 1'b1, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!(bus.av_chipselect && bus.av_address == 3'd3) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("reached_wr_ph", bus.av_address, 3'd3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", bus.av_chipselect, 1'b0);
    chk("midrst_write_n", bus.av_write_n, 1'b1);
    chk("midrst_count", timeout_count, 0);
    chk("midrst_ready", cmd_ready, 1'b0);
    exp_bus.delete();
    model_count = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", bus.av_chipselect, 1'b0);

    // Five serviced IRQs on a 2-bit counter wrap to 1
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      raise_irq();
    end
    wait_ready();
    repeat (4) @(negedge clk);
    chk("count_wrap", timeout_count, 1);

    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("snap_queue_empty", exp_snap.size(), 0);
    chk("count_queue_empty", exp_cnt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
